// File: rtl/quant_readout_ctrl_pkg.sv
// Shared types and helpers for the column readout sequencer:
// FSM states, range modes, mode decode and 6-to-4 bit reduction.
package quant_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_WAIT,
    S_PACK,
    S_EMIT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    M_COL,
    M_R16,
    M_R8,
    M_R4,
    M_R2,
    M_R1,
    M_ZERO
  } mode_e;

  function automatic mode_e rows_to_mode(
    input logic       col_en,
    input logic [4:0] rows
  );
    mode_e m;
    m = M_ZERO;
    unique case (1'b1)
      col_en:                        m = M_COL;
      !col_en && rows >= 5'd9:       m = M_R16;
      !col_en && rows inside {[5:8]}: m = M_R8;
      !col_en && rows inside {[3:4]}: m = M_R4;
      !col_en && rows == 5'd2:       m = M_R2;
      !col_en && rows == 5'd1:       m = M_R1;
      !col_en && rows == 5'd0:       m = M_ZERO;
      default:                       m = M_ZERO;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] quant6to4(
    input mode_e      mode,
    input logic [5:0] b
  );
    logic [3:0] q;
    q = 4'h0;
    unique case (mode)
      M_COL:  q = {b[2:0], 1'b0};
      M_R16:  q = b[5:2];
      M_R8:   q = b[5] ? 4'hF : b[4:1];
      M_R4:   q = b[4] ? 4'hF : b[3:0];
      M_R2:   q = b[3] ? 4'hE : {b[2:0], 1'b0};
      M_R1:   q = b[2] ? 4'hC : {b[1:0], 2'b00};
      M_ZERO: q = 4'h0;
      default: q = 4'h0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/quant_readout_ctrl_if.sv
// Packed-word stream from the readout sequencer
// to the activation buffer (valid/ready).
interface quant_readout_ctrl_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/quant_readout_ctrl_packer.sv
// 16-bit word register built from four nibble slots,
// with per-slot write enable and a whole-word clear.
module quant_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        we,
  input  logic [1:0]  slot,
  input  logic [3:0]  nib,
  output logic [15:0] word
);

  logic [15:0] word_d;
  logic [15:0] word_q;

  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (we) begin
      word_d[{slot, 2'b00} +: 4] = nib;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/quant_readout_ctrl.sv
// Column readout sequencer: steps columns, triggers the ADC,
// reduces samples to nibbles and streams packed 16-bit words.
module quant_readout_ctrl
  import quant_ctrl_pkg::*;
#(
  parameter int NUM_COLS    = 16,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [4:0]                  cfg_rows,
  input  logic                        cfg_col_en,
  output logic                        adc_start,
  output logic [$clog2(NUM_COLS)-1:0] adc_col,
  input  logic                        adc_valid,
  input  logic [5:0]                  adc_data,
  quant_readout_ctrl_if.master        ob,
  output logic                        busy,
  output logic                        done,
  output logic                        err_timeout
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int TW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(ADC_TIMEOUT);

  state_e        state_d, state_q;
  mode_e         mode_d, mode_q;
  logic [CW-1:0] col_d, col_q;
  logic [TW-1:0] tmo_d, tmo_q;
  logic          err_d, err_q;

  logic          w_clr;
  logic          w_we;
  logic [3:0]    w_nib;
  logic [1:0]    slot;
  logic          last;
  logic [15:0]   word;

  assign slot = 2'(col_q);
  assign last = (col_q == LAST_COL);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    col_d   = col_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    w_clr   = 1'b0;
    w_we    = 1'b0;
    w_nib   = 4'h0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = rows_to_mode(cfg_col_en, cfg_rows);
          col_d   = '0;
          err_d   = 1'b0;
          w_clr   = 1'b1;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a conversion landing on the timeout cycle still counts
        if (adc_valid) begin
          w_we    = 1'b1;
          w_nib   = quant6to4(mode_q, adc_data);
          state_d = S_PACK;
        end else if (tmo_q == TMO_MAX) begin
          w_we    = 1'b1;
          err_d   = 1'b1;
          state_d = S_PACK;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_PACK: begin
        if (slot == 2'd3 || last) begin
          state_d = S_EMIT;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = S_SAMPLE;
        end
      end
      S_EMIT: begin
        if (ob.out_ready) begin
          w_clr = 1'b1;
          if (last) begin
            state_d = S_DONE;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = S_SAMPLE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_ZERO;
      col_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  quant_word_packer u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .we    (w_we),
    .slot  (slot),
    .nib   (w_nib),
    .word  (word)
  );

  assign adc_start    = (state_q == S_SAMPLE);
  assign adc_col      = col_q;
  assign ob.out_data  = word;
  assign ob.out_valid = (state_q == S_EMIT);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err_timeout  = err_q;

endmodule
